fetch_unit: RTL and testbench

Instruction-fetch stage of the multi-cycle core, directly upstream of the decoder. Owns the program counter. Fetches one instruction word from instruction memory in the FETCH state over a req/ack handshake, and holds it stable on `instr_raw` for DECODE and later states. Computes the next PC on entry to WRITE from the control and ALU results of the current instruction.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: controller phase encoding, the nop word, and the
// fetch-unit FSM state type.
package cpu_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_WAIT  = 2'd1,
    FS_DONE  = 2'd2,
    FS_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per FETCH phase over a
// req/ack handshake and computes the next PC on entry to WRITE.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_raw,
  output logic        fetch_done,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_uc,
  input  logic        branch_c,
  input  logic        branch_relative,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        fault
);

  localparam int TW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(FETCH_TIMEOUT - 1);

  fetch_state_t  fsm;
  logic [2:0]    state_q;
  logic [TW-1:0] tmo_cnt;

  logic          fetch_entry, write_entry;
  logic          taken, misaligned;
  logic [31:0]   target, next_pc;

  assign fetch_entry = (state == ST_FETCH) && (state_q != ST_FETCH);
  assign write_entry = (state == ST_WRITE) && (state_q != ST_WRITE);

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  always_comb begin
    taken      = branch_uc | (branch_c & alu_result[0]);
    target     = branch_relative ? (pc + imm) : {alu_result[31:1], 1'b0};
    misaligned = taken && (target[1:0] != 2'b00);
    next_pc    = taken ? target : pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= FS_IDLE;
      state_q    <= ST_WRITE;
      tmo_cnt    <= '0;
      pc         <= RESET_PC;
      instr_raw  <= NOP_INSTR;
      imem_req   <= 1'b0;
      fetch_done <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state;
      fetch_done <= 1'b0;
      case (fsm)
        FS_IDLE: begin
          if (fetch_entry) begin
            fsm      <= FS_WAIT;
            imem_req <= 1'b1;
            tmo_cnt  <= '0;
          end
        end
        FS_WAIT: begin
          if (imem_ack) begin
            instr_raw  <= imem_rdata;
            fsm        <= FS_DONE;
            imem_req   <= 1'b0;
            fetch_done <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            fsm      <= FS_FAULT;
            imem_req <= 1'b0;
            fault    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        FS_DONE:  fsm <= FS_IDLE;
        FS_FAULT: fsm <= FS_FAULT;
        default:  fsm <= FS_IDLE;
      endcase

      // A misaligned taken target leaves pc alone and parks the block in FAULT.
      if (write_entry && fsm != FS_FAULT) begin
        if (misaligned) begin
          fsm        <= FS_FAULT;
          fault      <= 1'b1;
          imem_req   <= 1'b0;
          fetch_done <= 1'b0;
        end else begin
          pc <= next_pc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a PC/instruction model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h100;
  localparam int          TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_raw;
  logic        fetch_done;
  logic [31:0] pc, pc_plus4;
  logic        branch_uc, branch_c, branch_relative;
  logic [31:0] imm, alu_result;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  logic [31:0] pc_m;
  logic [31:0] instr_m;
  logic        fault_m;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .state(state),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_raw(instr_raw), .fetch_done(fetch_done),
    .pc(pc), .pc_plus4(pc_plus4),
    .branch_uc(branch_uc), .branch_c(branch_c), .branch_relative(branch_relative),
    .imm(imm), .alu_result(alu_result), .fault(fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; state = 3'd4; imem_ack = 1'b0; imem_rdata = '0;
    branch_uc = 0; branch_c = 0; branch_relative = 0; imm = '0; alu_result = '0;
    tick(); tick();
    rst = 1'b0;
    pc_m = RPC; instr_m = 32'h13; fault_m = 1'b0;
  endtask

  // Fetch with 'dly' ack-less WAIT cycles, then an ack carrying 'word'.
  task automatic do_fetch(input int dly, input logic [31:0] word, input string nm);
    state = 3'd0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== pc_m) begin
      failures++;
      $display("FAIL %s req/addr: got req=%b addr=%h want req=1 addr=%h", nm, imem_req, imem_addr, pc_m);
    end
    for (int i = 0; i < dly; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== pc_m || fetch_done !== 1'b0) begin
        failures++;
        $display("FAIL %s wait%0d: got req=%b addr=%h done=%b want 1 %h 0", nm, i, imem_req, imem_addr, fetch_done, pc_m);
      end
    end
    imem_ack = 1'b1; imem_rdata = word;
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
    instr_m = word;
    checks++;
    if (fetch_done !== 1'b1 || instr_raw !== instr_m || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL %s done: got done=%b instr=%h req=%b want 1 %h 0", nm, fetch_done, instr_raw, imem_req, instr_m);
    end
    state = 3'd1;
    tick();
    checks++;
    if (fetch_done !== 1'b0 || instr_raw !== instr_m) begin
      failures++;
      $display("FAIL %s pulse: got done=%b instr=%h want 0 %h", nm, fetch_done, instr_raw, instr_m);
    end
  endtask

  // EXEC then WRITE with the given branch inputs; the model applies the rules.
  task automatic do_write(input logic bu, input logic bc, input logic br,
                          input logic [31:0] im, input logic [31:0] alu, input string nm);
    logic tk;
    logic [31:0] tgt;
    branch_uc = bu; branch_c = bc; branch_relative = br; imm = im; alu_result = alu;
    state = 3'd2;
    tick();
    checks++;
    if (pc_plus4 !== pc_m + 32'd4) begin
      failures++;
      $display("FAIL %s pc_plus4: got %h want %h", nm, pc_plus4, pc_m + 32'd4);
    end
    state = 3'd4;
    tick();
    tk  = bu | (bc & alu[0]);
    tgt = br ? pc_m + im : (alu & 32'hFFFF_FFFE);
    if (!fault_m) begin
      if (tk && tgt[1:0] != 2'b00) fault_m = 1'b1;
      else pc_m = tk ? tgt : pc_m + 32'd4;
    end
    checks++;
    if (pc !== pc_m || fault !== fault_m) begin
      failures++;
      $display("FAIL %s pc: got pc=%h fault=%b want pc=%h fault=%b", nm, pc, fault, pc_m, fault_m);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== RPC || instr_raw !== 32'h13 || imem_req !== 1'b0 || fault !== 1'b0 || fetch_done !== 1'b0) begin
      failures++;
      $display("FAIL reset: got pc=%h instr=%h req=%b fault=%b done=%b", pc, instr_raw, imem_req, fault, fetch_done);
    end
  endtask

  task automatic test_zero_wait();
    do_fetch(0, 32'h0050_0093, "zero_wait");
    do_write(0, 0, 0, 0, 0, "zero_wait_seq");
  endtask

  task automatic test_delay();
    do_fetch(3, 32'hDEAD_BEEF, "delay3");
  endtask

  task automatic test_branches();
    do_reset();
    do_fetch(0, 32'h1, "br_a_fetch");
    do_write(0, 1, 1, 32'hFFFF_FFF8, 32'h1, "br_cond_taken");
    checks++;
    if (pc !== 32'hF8) begin failures++; $display("FAIL br_cond_taken abs: got %h want 000000f8", pc); end
    do_reset();
    do_fetch(1, 32'h2, "br_b_fetch");
    do_write(0, 1, 1, 32'hFFFF_FFF8, 32'h0, "br_cond_not");
    checks++;
    if (pc !== 32'h104) begin failures++; $display("FAIL br_cond_not abs: got %h want 00000104", pc); end
    do_reset();
    do_fetch(0, 32'h3, "br_c_fetch");
    do_write(1, 0, 0, 32'h0, 32'h203, "br_misalign");
    checks++;
    if (fault !== 1'b1 || pc !== 32'h100 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL br_misalign abs: got fault=%b pc=%h req=%b want 1 00000100 0", fault, pc, imem_req);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] alu, im;
      do_fetch($urandom_range(0, 4), $urandom, "rnd_fetch");
      im  = $urandom_range(0, 7) == 0 ? $urandom : ($urandom & 32'hFFFF_FFFC);
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1] = 1'b0;
      do_write($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1), im, alu, "rnd_write");
      if (fault_m) do_reset();
    end
    // PC wrap-around at the top of the address space
    do_reset();
    do_fetch(0, 32'h5, "wrap_fetch");
    do_write(1, 0, 0, 32'h0, 32'hFFFF_FFFC, "wrap_jump");
    do_fetch(0, 32'h6, "wrap_fetch2");
    do_write(0, 0, 0, 32'h0, 32'h0, "wrap_inc");
    checks++;
    if (pc !== 32'h0) begin failures++; $display("FAIL wrap: got %h want 00000000", pc); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    state = 3'd0;
    tick();
    n = 0;
    while (imem_req === 1'b1 && n < 400) begin
      n++;
      tick();
    end
    checks++;
    if (n != TMO || fault !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL timeout: got req_cycles=%0d fault=%b req=%b want %0d 1 0", n, fault, imem_req, TMO);
    end
    state = 3'd1; tick();
    state = 3'd0; tick(); tick();
    checks++;
    if (imem_req !== 1'b0 || fault !== 1'b1) begin
      failures++;
      $display("FAIL timeout_refetch: got req=%b fault=%b want 0 1", imem_req, fault);
    end
  endtask

  task automatic test_rst_mid_wait();
    do_reset();
    state = 3'd0;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_wait req: got %b want 0", imem_req); end
    rst = 1'b0; state = 3'd1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (fetch_done !== 1'b0 || instr_raw !== 32'h13 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait late_ack: got done=%b instr=%h req=%b want 0 00000013 0", fetch_done, instr_raw, imem_req);
    end
    tick();
    checks++;
    if (fetch_done !== 1'b0) begin failures++; $display("FAIL rst_wait pulse: got %b want 0", fetch_done); end
    pc_m = RPC; instr_m = 32'h13; fault_m = 1'b0;
    do_fetch(2, 32'h0000_0073, "rst_wait_idle");
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delay();
    test_branches();
    test_random();
    test_timeout();
    test_rst_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
